// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional stall watchdog: define PIPELINE_CTRL_WDOG_EN.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  localparam logic [31:0] EXC_ERET = 32'h0000000e;

  state_t      state_q;
  state_t      state_d;
  logic        flush_q;
  logic        flush_d;
  logic [31:0] new_pc_q;
  logic [31:0] new_pc_d;
  logic        exc;

  assign exc = (excepttype_i != 32'd0);

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    stall    = 6'b000000;
    unique case (state_q)
      IDLE: begin
        if (exc) begin
          // freeze everything so the faulting instr stays put
          stall    = 6'b111111;
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (excepttype_i == EXC_ERET) ?
                     cp0_epc_i : EXC_VECTOR;
        end else begin
          priority case (1'b1)
            stallreq_from_mem: stall = 6'b011111;
            stallreq_from_ex:  stall = 6'b001111;
            stallreq_from_id:  stall = 6'b000111;
            default:           stall = 6'b000000;
          endcase
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

`ifdef PIPELINE_CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WDOG_LIMIT - 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_to  <= 1'b0;
    end else begin
      wd_to <= 1'b0;
      if (state_q == FLUSH || stall == 6'd0) begin
        wd_cnt <= '0;
      end else if (wd_cnt == LAST) begin
        wd_cnt <= '0;
        wd_to  <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + CW'(1);
      end
    end
  end

  assign stall_timeout = wd_to;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl.
// Watchdog expectations follow PIPELINE_CTRL_WDOG_EN.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam logic [31:0] VEC = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_r, ex_r, mem_r;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        id, ex, mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        chk_to;
    logic        to;
  } vec_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        chk_to;
    logic        to;
  } exp_t;

  exp_t sb[$];

  pipeline_ctrl #(
    .EXC_VECTOR(VEC),
    .WDOG_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_from_id(id_r),
    .stallreq_from_ex(ex_r),
    .stallreq_from_mem(mem_r),
    .excepttype_i(exc),
    .cp0_epc_i(epc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic i, input logic e,
    input logic m, input logic [31:0] x,
    input logic [31:0] p, input logic [5:0] s,
    input logic f, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.id = i; v.ex = e; v.mem = m;
    v.exc = x; v.epc = p; v.stall = s;
    v.flush = f; v.npc = n;
    v.chk_to = 1'b0; v.to = 1'b0;
    return v;
  endfunction

  // drive one cycle of stimulus and queue its expectation
  task automatic drive(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; id_r = v.id; ex_r = v.ex;
    mem_r = v.mem; exc = v.exc; epc = v.epc;
    e.stall = v.stall; e.flush = v.flush;
    e.npc = v.npc; e.chk_to = v.chk_to; e.to = v.to;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    vec_t v = mk(1,0,0,0,0,0,6'h00,0,0);
    v.chk_to = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(v);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL reset_flush got %b want %b", flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL reset_npc got %h want %h", new_pc, e.npc);
      end
      if (stall_timeout !== e.to) begin
        n_bad++;
        $display("FAIL reset_to got %b want %b", stall_timeout, e.to);
      end
    end
  endtask

  task automatic test_stall_priority();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(0,1,0,0,0,0,6'b000111,0,0));
    v.push_back(mk(0,1,1,0,0,0,6'b001111,0,0));
    v.push_back(mk(0,1,1,1,0,0,6'b011111,0,0));
    v.push_back(mk(0,0,0,1,0,0,6'b011111,0,0));
    v.push_back(mk(0,0,1,0,0,0,6'b001111,0,0));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,0,0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL prio_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL prio_flush[%0d] got %b want %b", i, flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL prio_npc[%0d] got %h want %h", i, new_pc, e.npc);
      end
    end
  endtask

  task automatic test_syscall();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(0,0,0,0,32'h8,0,6'b111111,0,0));
    v.push_back(mk(0,1,0,0,0,0,6'b000000,1,VEC));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,0,VEC));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL sys_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL sys_flush[%0d] got %b want %b", i, flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL sys_npc[%0d] got %h want %h", i, new_pc, e.npc);
      end
    end
  endtask

  task automatic test_eret();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(0,0,0,0,32'he,32'hbfc00124,6'b111111,0,VEC));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,1,32'hbfc00124));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,0,32'hbfc00124));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL eret_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL eret_flush[%0d] got %b want %b", i, flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL eret_npc[%0d] got %h want %h", i, new_pc, e.npc);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    logic [31:0] p = 32'h80001000;
    v.push_back(mk(0,0,0,1,32'hc,0,6'b111111,0,32'hbfc00124));
    v.push_back(mk(0,0,0,1,32'h8,0,6'b000000,1,VEC));
    v.push_back(mk(0,0,0,0,32'h8,0,6'b111111,0,VEC));
    v.push_back(mk(0,0,0,0,32'he,p,6'b000000,1,VEC));
    v.push_back(mk(0,0,0,0,32'he,p,6'b111111,0,VEC));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,1,p));
    v.push_back(mk(0,0,1,0,0,0,6'b001111,0,p));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL b2b_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL b2b_flush[%0d] got %b want %b", i, flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL b2b_npc[%0d] got %h want %h", i, new_pc, e.npc);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(0,0,0,0,32'h9,0,6'b111111,0,32'h80001000));
    v.push_back(mk(1,1,0,0,0,0,6'b000000,1,VEC));
    v.push_back(mk(0,0,1,0,0,0,6'b001111,0,0));
    v.push_back(mk(0,0,0,0,0,0,6'b000000,0,0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 3;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL rstfl_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (flush !== e.flush) begin
        n_bad++;
        $display("FAIL rstfl_flush[%0d] got %b want %b", i, flush, e.flush);
      end
      if (new_pc !== e.npc) begin
        n_bad++;
        $display("FAIL rstfl_npc[%0d] got %h want %h", i, new_pc, e.npc);
      end
    end
  endtask

  task automatic test_watchdog();
    vec_t v;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) v = mk(0,0,1,0,0,0,6'b001111,0,0);
      else        v = mk(0,0,0,0,0,0,6'b000000,0,0);
      v.chk_to = 1'b1;
      v.to = WD && (i == 4 || i == 8);
      drive(v);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp += 2;
      if (stall !== e.stall) begin
        n_bad++;
        $display("FAIL wd_stall[%0d] got %b want %b", i, stall, e.stall);
      end
      if (stall_timeout !== e.to) begin
        n_bad++;
        $display("FAIL wd_to[%0d] got %b want %b", i, stall_timeout, e.to);
      end
    end
  endtask

  initial begin
    rst = 1'b1; id_r = 1'b0; ex_r = 1'b0;
    mem_r = 1'b0; exc = '0; epc = '0;
    test_reset();
    test_stall_priority();
    test_syscall();
    test_eret();
    test_back_to_back();
    test_reset_in_flush();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
